// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM encoding and bit-timing helper,
// common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is
// chosen to match the idle level of the line being synchronised.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync <= {2{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of an asynchronous serial line, LSB first,
// with one-cycle strobes for good byte, framing error and line break.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break
);

  localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int unsigned CW             = 1 + $clog2(CYCLES_PER_BIT);
  localparam int unsigned IW             = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  uart_state_t             r_state;
  uart_state_t             w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_bit_idx;
  logic                    r_stop_idx;
  logic                    r_err;
  logic                    r_seen_high;
  logic [PAYLOAD_BITS-1:0] r_shift;

  logic w_rxd_s;
  logic w_cnt_half;
  logic w_cnt_full;
  logic w_last_bit;
  logic w_last_stop;
  logic w_start_ok;
  logic w_err_final;

  logic w_cnt_clr;
  logic w_accept;
  logic w_shift;
  logic w_stop_smp;
  logic w_frame_done;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync_rxd (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (uart_rxd),
    .o_q    (w_rxd_s)
  );

  assign w_cnt_half  = (r_cnt == CW'(HALF_BIT - 1));
  assign w_cnt_full  = (r_cnt == CW'(CYCLES_PER_BIT - 1));
  assign w_last_bit  = (r_bit_idx == IW'(PAYLOAD_BITS - 1));
  assign w_last_stop = (r_stop_idx == 1'(STOP_BITS - 1));
  // A new start is only accepted once the line has been seen high in IDLE,
  // so a held-low line after a break cannot re-trigger.
  assign w_start_ok  = !w_rxd_s && uart_rx_en && r_seen_high;
  assign w_err_final = r_err || !w_rxd_s;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start_ok) w_state_nxt = START;
      end
      START: begin
        if (w_cnt_half) w_state_nxt = w_rxd_s ? IDLE : DATA;
      end
      DATA: begin
        if (w_cnt_full && w_last_bit) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_cnt_full && w_last_stop) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_clr    = 1'b0;
    w_accept     = 1'b0;
    w_shift      = 1'b0;
    w_stop_smp   = 1'b0;
    w_frame_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_clr = 1'b1;
        w_accept  = w_start_ok;
      end
      START: begin
        w_cnt_clr = w_cnt_half;
      end
      DATA: begin
        w_cnt_clr = w_cnt_full;
        w_shift   = w_cnt_full;
      end
      STOP: begin
        w_cnt_clr    = w_cnt_full;
        w_stop_smp   = w_cnt_full;
        w_frame_done = w_cnt_full && w_last_stop;
      end
      default: w_cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_stop_idx  <= 1'b0;
      r_err       <= 1'b0;
      r_seen_high <= 1'b0;
      r_shift     <= '0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + CW'(1);

      if (r_state == START) begin
        r_bit_idx <= '0;
      end else if (w_shift) begin
        r_bit_idx <= r_bit_idx + IW'(1);
      end

      if (r_state == DATA) begin
        r_stop_idx <= 1'b0;
        r_err      <= 1'b0;
      end else if (w_stop_smp) begin
        r_stop_idx <= r_stop_idx + 1'b1;
        r_err      <= w_err_final;
      end

      if (w_accept) begin
        r_seen_high <= 1'b0;
      end else if (r_state == IDLE && w_rxd_s) begin
        r_seen_high <= 1'b1;
      end

      if (w_shift) begin
        r_shift <= {w_rxd_s, r_shift[PAYLOAD_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_break     <= 1'b0;
      uart_rx_data      <= '0;
    end else begin
      uart_rx_valid     <= w_frame_done && !w_err_final;
      uart_rx_frame_err <= w_frame_done && w_err_final;
      uart_rx_break     <= w_frame_done && w_err_final && (r_shift == '0);
      if (w_frame_done && !w_err_final) begin
        uart_rx_data <= r_shift;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clocks per bit: expected strobes are
// queued as frames are driven and matched as the receiver emits them.
module tb_uart_rx;

  localparam int CPB = 10;

  typedef struct {
    int         kind;   // 0 valid, 1 frame_err, 2 break
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       uart_rx_en = 1'b1;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_frame_err;
  logic       uart_rx_break;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   t_start = 0;
  int   t_a5;
  int   vt[$];
  exp_t q[$];

  uart_rx #(
    .BIT_RATE     (100_000),
    .CLK_HZ       (1_000_000),
    .PAYLOAD_BITS (8),
    .STOP_BITS    (1)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .uart_rxd          (uart_rxd),
    .uart_rx_en        (uart_rx_en),
    .uart_rx_valid     (uart_rx_valid),
    .uart_rx_data      (uart_rx_data),
    .uart_rx_frame_err (uart_rx_frame_err),
    .uart_rx_break     (uart_rx_break)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int kind, input logic [7:0] d);
    exp_t e;
    e.kind = kind;
    e.data = d;
    q.push_back(e);
  endtask

  // Drives one frame starting at the current negedge; leaves the line high.
  // rst_bit >= 0 holds resetn low from mid data bit rst_bit to frame end.
  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int rst_bit);
    t_start  = cyc;
    uart_rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      if (i == rst_bit) begin
        wait_cyc(CPB / 2);
        resetn = 1'b0;
        wait_cyc(CPB - CPB / 2);
      end else begin
        wait_cyc(CPB);
      end
    end
    uart_rxd = stop_lvl;
    wait_cyc(CPB);
    uart_rxd = 1'b1;
    if (rst_bit >= 0) begin
      chk("rst_valid", uart_rx_valid, 0);
      chk("rst_ferr", uart_rx_frame_err, 0);
      chk("rst_break", uart_rx_break, 0);
      chk("rst_data", uart_rx_data, 0);
      resetn = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (uart_rx_valid || uart_rx_frame_err || uart_rx_break) begin
      int   k;
      exp_t e;
      k = uart_rx_break ? 2 : (uart_rx_frame_err ? 1 : 0);
      chk("excl", uart_rx_valid && uart_rx_frame_err, 0);
      if (uart_rx_break) chk("brk_ferr", uart_rx_frame_err, 1);
      if (q.size() == 0) begin
        chk("unexpected", k + 1, 0);
      end else begin
        e = q.pop_front();
        chk("kind", k, e.kind);
        chk("data", uart_rx_data, e.data);
      end
      if (uart_rx_valid) vt.push_back(cyc);
    end
  end

  initial begin
    #500_000;
    $display("FAIL timeout: stimulus did not complete");
    $fatal(1);
  end

  initial begin
    wait_cyc(4);
    chk("reset_valid", uart_rx_valid, 0);
    chk("reset_ferr", uart_rx_frame_err, 0);
    chk("reset_break", uart_rx_break, 0);
    chk("reset_data", uart_rx_data, 0);
    resetn = 1'b1;
    wait_cyc(5);

    // Single frame and latency from start edge to valid
    vt.delete();
    push_exp(0, 8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    t_a5 = t_start;
    wait_cyc(20);
    chk("a5_count", vt.size(), 1);
    if (vt.size() > 0) chk("a5_latency", vt[0] - t_a5, 98);

    // Back-to-back frames, no idle gap
    vt.delete();
    push_exp(0, 8'h00);
    push_exp(0, 8'hFF);
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    wait_cyc(20);
    chk("b2b_count", vt.size(), 2);
    if (vt.size() == 2) chk("b2b_spacing", vt[1] - vt[0], 100);

    // Start glitch, then a good frame
    uart_rxd = 1'b0;
    wait_cyc(3);
    uart_rxd = 1'b1;
    wait_cyc(30);
    chk("glitch_none", q.size(), 0);
    push_exp(0, 8'h3C);
    send_frame(8'h3C, 1'b1, -1);
    wait_cyc(20);

    // Framing error keeps last good byte; break fires once while held low
    push_exp(1, 8'h3C);
    send_frame(8'h55, 1'b0, -1);
    wait_cyc(20);
    push_exp(2, 8'h3C);
    uart_rxd = 1'b0;
    wait_cyc(200);
    uart_rxd = 1'b1;
    wait_cyc(30);
    chk("break_drained", q.size(), 0);

    // Disabled receiver ignores a frame
    uart_rx_en = 1'b0;
    send_frame(8'h12, 1'b1, -1);
    wait_cyc(5);
    uart_rx_en = 1'b1;
    wait_cyc(20);

    // Reset during data bit 4, then a good frame
    send_frame(8'h77, 1'b1, 4);
    wait_cyc(20);
    chk("post_rst_data", uart_rx_data, 0);
    push_exp(0, 8'h81);
    send_frame(8'h81, 1'b1, -1);
    wait_cyc(20);

    chk("pending", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
